// File: rtl/transceiver_pkg.sv
// Shared definitions for the TX shift transmitter and the RX shift sampler.
package transceiver_pkg;

    // Frame length in bits; both ends of the link must agree on it.
    localparam int FRAME_W = 80;

    // Level forced onto the first transmitted bit so the receiver can start.
    localparam logic START_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/shift_transmitter.sv
// Serialises one frame MSB first (first bit forced high), then holds the line
// low for a guard gap so the receiver can re-arm before the next frame.
module shift_transmitter
    import transceiver_pkg::*;
#(
    parameter int FRAME_W    = transceiver_pkg::FRAME_W,
    parameter int GAP_CYCLES = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_frame_valid,
    output logic               o_frame_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic [15:0]        o_frames_sent
);

    localparam int CNT_W = $clog2(FRAME_W);
    localparam int GAP_W = 8;
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_next;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_done_next;
    logic [15:0]        r_frames_sent;
    logic               w_accept;
    logic [FRAME_W-1:0] w_frame_load;

    assign w_accept     = (r_state == IDLE) && r_ready && i_frame_valid;
    assign w_frame_load = {START_BIT, i_frame[FRAME_W-2:0]};

    // Next-state decision; transitions fire when the active counter hits zero.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)          w_state_next = SEND;
            SEND:    if (r_bit_cnt == '0)   w_state_next = GAP;
            GAP:     if (r_gap_cnt == '0)   w_state_next = IDLE;
            default:                        w_state_next = IDLE;
        endcase
    end

    // Next values for the gap counter and the registered done pulse.
    always_comb begin
        w_gap_next = r_gap_cnt;
        if (r_state == SEND && r_bit_cnt == '0) begin
            w_gap_next = GAP_LOAD;
        end else if (r_state == GAP && r_gap_cnt != '0) begin
            w_gap_next = r_gap_cnt - 1'b1;
        end
        // Done must be visible during the last gap cycle, so it is set one edge early.
        w_done_next = (w_state_next == GAP) && (w_gap_next == '0);
    end

    // State register, shift register, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every register updating on the same edge.
        if (i_rst) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_next;
            r_ready   <= (w_state_next == IDLE);
            r_busy    <= (w_state_next != IDLE);
            r_done    <= w_done_next;

            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= w_frame_load;
                        r_bit_cnt <= BIT_LOAD;
                    end
                end
                SEND: begin
                    // Zero fill leaves the register clear after the last bit,
                    // which is what keeps the line low in GAP and IDLE.
                    r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_frames_sent <= r_frames_sent + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx          = r_shreg[FRAME_W-1];
    assign o_frame_ready = r_ready;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_done;
    assign o_frames_sent = r_frames_sent;

endmodule

// File: doc/shift_transmitter.md
# shift_transmitter

- Transmit-side counterpart of the RX `shift_sampler`.
- Accepts one 80-bit frame through a valid/ready handshake and shifts it out MSB first on a single serial line, one bit per 40 kHz `clk` cycle.
- Bit 79 is always sent as 1, because the receiver only starts capturing on a high level; a low guard gap follows every frame so the receiver can re-arm.
- Sits between the TX frame source and the TX PCB driver input.

## Interface
- `FRAME_W`, 80, frame length in bits; must equal the receiver's sample count.
- `GAP_CYCLES`, 8, idle-low cycles forced after each frame; range 1..255.
- `clk` input 1: 40 kHz generated clock, the same rate as the receiver.
- `rst` input 1: reset; synchronous, active-high.
- `frame` input FRAME_W: frame to send; bit FRAME_W-1 goes out first.
- `frame_valid` input 1: `frame` is valid.
- `frame_ready` output 1: block can accept a frame this cycle.
- `tx` output 1: serial line to the TX PCB.
- `busy` output 1: high while in SEND or GAP.
- `frame_done` output 1: one-cycle pulse on the last GAP cycle.
- `frames_sent` output 16: count of completed frames, wraps.

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - `tx`=0, `frame_ready`=1.
  - When `frame_valid` && `frame_ready` at a rising edge:
    - `frame` is captured into the shift register, with bit FRAME_W-1 forced to 1 regardless of input.
    - Bit counter loads FRAME_W-1; next state is SEND.
- SEND:
  - `tx` = shreg[FRAME_W-1]; shreg shifts left by one per cycle (zero fill); counter decrements.
  - When counter==0 (last bit on line), the next state is GAP and the gap counter loads GAP_CYCLES-1.
- GAP:
  - `tx`=0; gap counter decrements.
  - At gap counter==0: `frame_done`=1, `frames_sent` increments (mod 2^16), next state is IDLE.
- `frame_ready` is 0 in SEND and GAP. `frame_valid` in those states is ignored and nothing is queued; the source must hold valid until ready.
- `frame` is sampled only at the accept edge; later changes have no effect.
- Reset values:
  - state=IDLE, `tx`=0, `frame_ready`=1, `busy`=0, `frame_done`=0, `frames_sent`=0, shreg=0, counters=0.
- Reset mid-SEND or mid-GAP:
  - Next cycle is IDLE with `tx`=0; the partial frame is dropped and `frames_sent` is cleared.
  - The receiver may capture a truncated frame; that is acceptable and upstream handles it.
- `rst` and accept in the same cycle: reset wins and the frame is not accepted.
- Counter width is clog2(FRAME_W) bits. Counter arithmetic never underflows, because transitions occur at 0.

## Timing
- All outputs are registered.
- Accept at edge k: `tx` carries frame bit 79 (=1) during cycle k+1 and bit 79-i during cycle k+1+i, so bit 0 is on the line in cycle k+80.
- Cycles k+81 .. k+80+GAP_CYCLES: `tx`=0.
- `frame_done` is high in cycle k+80+GAP_CYCLES.
- `frame_ready` rises in cycle k+81+GAP_CYCLES. The earliest next accept is at the edge ending that cycle, so the minimum frame period is FRAME_W+GAP_CYCLES+1 cycles.
- `busy` is high in cycles k+1 .. k+80+GAP_CYCLES.
- Gap rationale: the receiver re-arms the cycle after its bit-0 sample. A gap of ≥1 low cycle prevents an immediate false start on residual high levels.

## Structure
- Shared package `transceiver_pkg` holds:
  - `FRAME_W` default (80), shared with the RX sampler;
  - state enum `tx_state_t` {IDLE, SEND, GAP};
  - start-bit constant `START_BIT = 1'b1`.
- Single module, no sub-module. Shift register, two down-counters and the FSM are in one sequential block, with a small next-state combinational block.

## Test plan
- Reset, then idle 10 cycles -> `tx`=0, `frame_ready`=1, `busy`=0, `frames_sent`=0 throughout.
- Send `frame`=80'hA5A5_0000_0000_0000_00FF with valid for one cycle:
  - `tx` over cycles k+1..k+80 equals 80'hA5A5_…_00FF MSB first;
  - then 8 zeros, `frame_done` at k+88, `frames_sent`=1.
- Send `frame`=0 -> first tx bit is 1 (forced start), remaining 79 bits 0. A loopback `shift_sampler` captures 80'h8000_0000_0000_0000_0000.
- Hold `frame_valid` high continuously with frames F1, F2 -> F2 accepted exactly 89 cycles after F1's accept; `frame_valid` during SEND/GAP is not accepted; F1 is unaffected by `frame` changing mid-send.
- Assert `rst` at bit 40 of a frame -> next cycle `tx`=0, state IDLE, `frames_sent`=0. A new frame accepted afterward transmits correctly.
- End-to-end loopback into `shift_sampler` with 100 random frames (bit 79 set) -> every captured sample equals the sent frame. Separately, `frames_sent` preset near 16'hFFFF wraps to 0.
